// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared width, opcodes and state encoding for the ALU sequencer
package alu_pkg;

  localparam int WIDTH = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    ITER = 2'b10,
    DONE = 2'b11
  } state_e;

endpackage

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - multi-cycle add/sub/mul/div sequencer around an external add/sub unit
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int ITERS = WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         opcode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               zero,
  output logic               div_zero,
  output logic [WIDTH-1:0]   add_x,
  output logic [WIDTH-1:0]   add_y,
  output logic               add_c_in,
  output logic               add_op,
  input  logic [WIDTH-1:0]   add_z,
  input  logic               add_c_out
);

  localparam int CNT_W = $clog2(ITERS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

  state_e               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     p_q, p_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 carry_q, carry_d;
  logic                 zero_q, zero_d;
  logic                 div_zero_q, div_zero_d;
  logic                 res_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      p_q        <= '0;
      q_q        <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      p_q        <= p_d;
      q_q        <= q_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      div_zero_q <= div_zero_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    p_d        = p_q;
    q_d        = q_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    div_zero_d = div_zero_q;
    res_load   = 1'b0;
    add_x      = '0;
    add_y      = '0;
    add_c_in   = 1'b0;
    add_op     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d       = opcode;
          a_d        = a;
          b_d        = b;
          p_d        = '0;
          cnt_d      = '0;
          div_zero_d = 1'b0;
          unique case (opcode)
            OP_MUL: begin
              q_d     = b;
              state_d = ITER;
            end
            OP_DIV: begin
              q_d     = a;
              // A zero divisor never enters the iteration loop.
              state_d = (b == '0) ? EXEC : ITER;
            end
            default: begin
              state_d = EXEC;
            end
          endcase
        end
      end

      EXEC: begin
        res_load = 1'b1;
        state_d  = DONE;
        if (op_q == OP_DIV) begin
          result_d   = {a_q, {WIDTH{1'b1}}};
          carry_d    = 1'b0;
          div_zero_d = 1'b1;
        end else begin
          add_x    = a_q;
          add_y    = b_q;
          add_c_in = (op_q == OP_SUB);
          add_op   = (op_q == OP_SUB);
          result_d = {{(WIDTH-1){1'b0}}, add_c_out, add_z};
          carry_d  = add_c_out;
        end
      end

      ITER: begin
        if (op_q == OP_MUL) begin
          add_x      = p_q;
          add_y      = q_q[0] ? a_q : '0;
          {p_d, q_d} = {add_c_out, add_z, q_q[WIDTH-1:1]};
        end else begin
          // Restoring step: R[7] set means the shifted remainder overflowed 8 bits,
          // so the subtraction must be kept regardless of the adder carry.
          add_x    = {p_q[WIDTH-2:0], q_q[WIDTH-1]};
          add_y    = b_q;
          add_c_in = 1'b1;
          add_op   = 1'b1;
          if (p_q[WIDTH-1] | add_c_out) begin
            p_d = add_z;
            q_d = {q_q[WIDTH-2:0], 1'b1};
          end else begin
            p_d = {p_q[WIDTH-2:0], q_q[WIDTH-1]};
            q_d = {q_q[WIDTH-2:0], 1'b0};
          end
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          res_load = 1'b1;
          result_d = {p_d, q_d};
          carry_d  = 1'b0;
          state_d  = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (res_load) begin
      zero_d = (result_d == '0);
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign result   = result_q;
  assign carry    = carry_q;
  assign zero     = zero_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - scoreboard bench for alu_seq_ctrl with a behavioural add/sub unit
module tb_alu_seq_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  opcode = 2'b00;
  logic [7:0]  a = 8'h00;
  logic [7:0]  b = 8'h00;
  logic        busy, done, carry, zero, div_zero;
  logic [15:0] result;
  logic [7:0]  add_x, add_y, add_z;
  logic        add_c_in, add_op, add_c_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  assign {add_c_out, add_z} = {1'b0, add_x} + {1'b0, (add_op ? ~add_y : add_y)} + {8'b0, add_c_in};

  alu_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .div_zero  (div_zero),
    .add_x     (add_x),
    .add_y     (add_y),
    .add_c_in  (add_c_in),
    .add_op    (add_op),
    .add_z     (add_z),
    .add_c_out (add_c_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [7:0] va, input logic [7:0] vb);
    exp_t e;
    logic [8:0] s;
    logic [7:0] d;
    e.c  = 1'b0;
    e.dz = 1'b0;
    e.lat = 9;
    case (op)
      OP_ADD: begin
        s     = {1'b0, va} + {1'b0, vb};
        e.res = {7'b0, s};
        e.c   = s[8];
        e.lat = 2;
      end
      OP_SUB: begin
        d     = va - vb;
        e.c   = (va >= vb);
        e.res = {7'b0, e.c, d};
        e.lat = 2;
      end
      OP_MUL: begin
        e.res = 16'(va) * 16'(vb);
      end
      default: begin
        if (vb == 8'd0) begin
          e.res = {va, 8'hFF};
          e.dz  = 1'b1;
          e.lat = 2;
        end else begin
          e.res = {8'(va % vb), 8'(va / vb)};
        end
      end
    endcase
    e.z = (e.res == 16'h0000);
    return e;
  endfunction

  task automatic run_op(input string tag, input logic [1:0] op, input logic [7:0] va,
                        input logic [7:0] vb, input int poke);
    exp_t e;
    int   n;
    bit   seen;
    sb.push_back(model(op, va, vb));
    opcode = op;
    a      = va;
    b      = vb;
    start  = 1'b1;
    @(posedge clk);
    n    = 0;
    seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
      end
      if (poke != 0 && n == poke) begin
        start  = 1'b1;
        opcode = OP_ADD;
        a      = 8'h11;
        b      = 8'h22;
      end
      if (poke != 0 && n == poke + 1) start = 1'b0;
      if (done) seen = 1;
    end
    start = 1'b0;
    e = sb.pop_front();
    if (!seen) begin
      chk({tag, "_done_timeout"}, 0, 1);
    end else begin
      chk({tag, "_latency"}, n, e.lat);
      chk({tag, "_result"}, result, e.res);
      chk({tag, "_carry"}, carry, e.c);
      chk({tag, "_zero"}, zero, e.z);
      chk({tag, "_div_zero"}, div_zero, e.dz);
      @(negedge clk);
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_idle"}, busy, 0);
      chk({tag, "_idle_add_bus"}, {add_x, add_y, add_c_in, add_op}, 0);
      chk({tag, "_result_hold"}, result, e.res);
    end
  endtask

  initial begin
    bit seen;

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {carry, zero, div_zero}, 0);
    chk("rst_add_bus", {add_x, add_y, add_c_in, add_op}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add_27_20", OP_ADD, 8'd27, 8'd20, 0);
    run_op("sub_40_33", OP_SUB, 8'd40, 8'd33, 0);
    run_op("sub_5_10", OP_SUB, 8'd5, 8'd10, 0);
    run_op("add_ff_01", OP_ADD, 8'hFF, 8'h01, 0);
    run_op("mul_255_255", OP_MUL, 8'd255, 8'd255, 0);
    run_op("mul_0_93", OP_MUL, 8'd0, 8'd93, 0);
    run_op("div_200_7", OP_DIV, 8'd200, 8'd7, 0);
    run_op("div_9_0", OP_DIV, 8'd9, 8'd0, 0);
    run_op("div_255_16", OP_DIV, 8'd255, 8'd16, 0);
    run_op("mul_13_11_poke", OP_MUL, 8'd13, 8'd11, 4);

    // Abandon a MUL with reset once the counter has reached 4.
    opcode = OP_MUL;
    a      = 8'd77;
    b      = 8'd99;
    start  = 1'b1;
    @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_flags", {carry, zero, div_zero}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    chk("abort_no_done", seen, 0);

    run_op("add_1_1", OP_ADD, 8'd1, 8'd1, 0);
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
